// File: rtl/apb_i2c_regif.sv
// APB3 register front-end for the APB-I2C bridge: holds the transaction setup,
// launches one engine transaction on START and captures the RX word when it ends.
module apb_i2c_regif #(
    parameter int ADDR_W    = 5,
    parameter int LAUNCH_TO = 16,
    parameter int RUN_TO    = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              irq,
    output logic              i2c_enable,
    output logic              i2c_rw,
    output logic              i2c_da,
    output logic              i2c_rep,
    output logic [1:0]        i2c_bytcount,
    output logic [6:0]        i2c_addr,
    output logic [31:0]       i2c_din,
    input  logic [31:0]       i2c_dout,
    input  logic [3:0]        i2c_istate
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LAUNCH  = 2'd1,
        S_RUN     = 2'd2,
        S_CAPTURE = 2'd3
    } seqState_t;

    seqState_t   state_q;
    logic [15:0] cnt_q;
    logic        enable_q;
    logic        rw_q;
    logic        da_q;
    logic        rep_q;
    logic [1:0]  bytcount_q;
    logic        irqEn_q;
    logic [6:0]  saddr_q;
    logic [31:0] txdata_q;
    logic [31:0] rxdata_q;
    logic        done_q;
    logic        err_q;

    logic        busy;
    logic        engineActive;
    logic        aligned;
    logic [2:0]  regSel;
    logic        wrAccess;
    logic        rdAccess;
    logic        wrCtrl;
    logic        wrSaddr;
    logic        wrTx;
    logic        wrRx;
    logic        wrStatus;
    logic        startBlocked;
    logic        ctrlCommit;
    logic        launch;

    assign busy         = (state_q != S_IDLE);
    assign engineActive = (i2c_istate != 4'd0);
    assign aligned      = (paddr[1:0] == 2'b00);
    assign regSel       = paddr[4:2];
    assign wrAccess     = psel & penable & pwrite & aligned;
    assign rdAccess     = psel & penable & ~pwrite & aligned;

    assign wrCtrl   = wrAccess & (regSel == 3'd0);
    assign wrSaddr  = wrAccess & (regSel == 3'd1);
    assign wrTx     = wrAccess & (regSel == 3'd2);
    assign wrRx     = wrAccess & (regSel == 3'd3);
    assign wrStatus = wrAccess & (regSel == 3'd4);

    // A START while the engine is still busy from elsewhere is refused as a whole.
    assign startBlocked = wrCtrl & pwdata[0] & engineActive;
    assign ctrlCommit   = wrCtrl & ~busy & ~startBlocked;
    assign launch       = ctrlCommit & pwdata[0];

    assign pslverr = ((wrCtrl | wrSaddr | wrTx) & busy) | wrRx | (startBlocked & ~busy);
    assign pready  = 1'b1;
    assign irq     = done_q & irqEn_q;

    assign i2c_enable   = enable_q;
    assign i2c_rw       = rw_q;
    assign i2c_da       = da_q;
    assign i2c_rep      = rep_q;
    assign i2c_bytcount = bytcount_q;
    assign i2c_addr     = saddr_q;
    assign i2c_din      = txdata_q;

    always_comb begin
        prdata = 32'd0;
        if (rdAccess) begin
            case (regSel)
                3'd0:    prdata = {23'd0, irqEn_q, 2'b00, bytcount_q, rep_q, da_q, rw_q, 1'b0};
                3'd1:    prdata = {25'd0, saddr_q};
                3'd2:    prdata = txdata_q;
                3'd3:    prdata = rxdata_q;
                3'd4:    prdata = {24'd0, i2c_istate, 1'b0, err_q, done_q, busy};
                default: prdata = 32'd0;
            endcase
        end
    end

    // Sequencer state updates come after the W1C so a same-cycle set of DONE wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 16'd0;
            enable_q   <= 1'b0;
            rw_q       <= 1'b0;
            da_q       <= 1'b0;
            rep_q      <= 1'b0;
            bytcount_q <= 2'd0;
            irqEn_q    <= 1'b0;
            saddr_q    <= 7'd0;
            txdata_q   <= 32'd0;
            rxdata_q   <= 32'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (ctrlCommit) begin
                rw_q       <= pwdata[1];
                da_q       <= pwdata[2];
                rep_q      <= pwdata[3];
                bytcount_q <= pwdata[5:4];
                irqEn_q    <= pwdata[8];
            end
            if (wrSaddr && !busy) begin
                saddr_q <= pwdata[6:0];
            end
            if (wrTx && !busy) begin
                txdata_q <= pwdata;
            end
            if (wrStatus) begin
                done_q <= done_q & ~pwdata[1];
                err_q  <= err_q & ~pwdata[2];
            end

            case (state_q)
                S_IDLE: begin
                    if (launch) begin
                        state_q  <= S_LAUNCH;
                        enable_q <= 1'b1;
                        cnt_q    <= 16'd0;
                        done_q   <= 1'b0;
                        err_q    <= 1'b0;
                    end
                end
                S_LAUNCH: begin
                    if (engineActive) begin
                        state_q  <= S_RUN;
                        enable_q <= 1'b0;
                        cnt_q    <= 16'd0;
                    end else if (cnt_q == 16'(LAUNCH_TO - 1)) begin
                        state_q  <= S_IDLE;
                        enable_q <= 1'b0;
                        err_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_RUN: begin
                    // The watchdog only flags the error; the engine keeps running.
                    if (!engineActive) begin
                        state_q <= S_CAPTURE;
                    end else if (cnt_q == 16'(RUN_TO - 1)) begin
                        state_q <= S_IDLE;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_CAPTURE: begin
                    rxdata_q <= i2c_dout;
                    done_q   <= 1'b1;
                    state_q  <= S_IDLE;
                end
                default: begin
                    state_q  <= S_IDLE;
                    enable_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_i2c_regif.sv
// Randomized self-checking bench for apb_i2c_regif: a register-level model of the
// APB view plus a behavioural I2C engine that answers transaction requests.
module tb_apb_i2c_regif;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [4:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        irq;
    logic        i2c_enable;
    logic        i2c_rw;
    logic        i2c_da;
    logic        i2c_rep;
    logic [1:0]  i2c_bytcount;
    logic [6:0]  i2c_addr;
    logic [31:0] i2c_din;
    logic [31:0] doutDrv;
    logic [3:0]  istateDrv;

    apb_i2c_regif dut (
        .clk          (clk),
        .rst          (rst),
        .psel         (psel),
        .penable      (penable),
        .pwrite       (pwrite),
        .paddr        (paddr),
        .pwdata       (pwdata),
        .prdata       (prdata),
        .pready       (pready),
        .pslverr      (pslverr),
        .irq          (irq),
        .i2c_enable   (i2c_enable),
        .i2c_rw       (i2c_rw),
        .i2c_da       (i2c_da),
        .i2c_rep      (i2c_rep),
        .i2c_bytcount (i2c_bytcount),
        .i2c_addr     (i2c_addr),
        .i2c_din      (i2c_din),
        .i2c_dout     (doutDrv),
        .i2c_istate   (istateDrv)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int preadyBad = 0;

    // Register-level expectation of what software should see.
    logic [31:0] mCtrl, mSaddr, mTx, mRx;
    bit          mDone, mErr, mBusy;

    // Behavioural engine controls and what it observed at launch.
    bit          engineOn = 1'b1;
    bit          engineBusy = 1'b0;
    int          runLen = 5;
    int          launchDly = 1;
    logic [31:0] engDout = 32'd0;
    logic [31:0] seenDin;
    logic [6:0]  seenAddr;
    logic [4:0]  seenMode;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] expRead(input logic [4:0] a);
        case (a)
            5'h00:   return mCtrl;
            5'h04:   return mSaddr;
            5'h08:   return mTx;
            5'h0C:   return mRx;
            5'h10:   return {24'd0, istateDrv, 1'b0, mErr, mDone, mBusy};
            default: return 32'd0;
        endcase
    endfunction

    // Applies the software-visible effect of a write; returns the expected error response.
    function automatic logic modelWrite(input logic [4:0] a, input logic [31:0] d);
        case (a)
            5'h00: begin
                if (mBusy || (d[0] && istateDrv != 4'd0)) return 1'b1;
                mCtrl = d & 32'h0000_013E;
                if (d[0]) begin
                    mBusy = 1'b1;
                    mDone = 1'b0;
                    mErr  = 1'b0;
                end
                return 1'b0;
            end
            5'h04: begin
                if (mBusy) return 1'b1;
                mSaddr = d & 32'h0000_007F;
                return 1'b0;
            end
            5'h08: begin
                if (mBusy) return 1'b1;
                mTx = d;
                return 1'b0;
            end
            5'h0C:   return 1'b1;
            5'h10: begin
                if (d[1]) mDone = 1'b0;
                if (d[2]) mErr = 1'b0;
                return 1'b0;
            end
            default: return 1'b0;
        endcase
    endfunction

    task automatic apbWrite(input logic [4:0] a, input logic [31:0] d, input string tag);
        logic expErr;
        expErr = modelWrite(a, d);
        @(negedge clk);
        psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        #1;
        checkOutput({tag, "_slverr"}, 32'(pslverr), 32'(expErr));
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apbRead(input logic [4:0] a, input string tag);
        @(negedge clk);
        psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        #1;
        checkOutput(tag, prdata, expRead(a));
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    // Waits for the engine to take and finish the request, then checks completion.
    task automatic waitDone(input string tag);
        int n;
        n = 0;
        while (!engineBusy && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_engStart"}, 32'(engineBusy), 32'd1);
        n = 0;
        while (engineBusy && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_engEnd"}, 32'(engineBusy), 32'd0);
        repeat (3) @(negedge clk);
        mBusy = 1'b0;
        mDone = 1'b1;
        mRx   = engDout;
        checkOutput({tag, "_enable"}, 32'(i2c_enable), 32'd0);
        checkOutput({tag, "_din"}, seenDin, mTx);
        checkOutput({tag, "_addr"}, 32'(seenAddr), mSaddr);
        checkOutput({tag, "_mode"}, 32'(seenMode), 32'(mCtrl[5:1]));
        checkOutput({tag, "_irq"}, 32'(irq), 32'(mDone & mCtrl[8]));
        apbRead(5'h0C, {tag, "_rxdata"});
        apbRead(5'h10, {tag, "_status"});
    endtask

    task automatic waitEngineActive(input string tag);
        int n;
        n = 0;
        while (istateDrv == 4'd0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_active"}, 32'(istateDrv != 4'd0), 32'd1);
    endtask

    task automatic applyStimulus(input int count);
        logic [31:0] ctrl;
        for (int i = 0; i < count; i++) begin
            ctrl      = ($urandom & 32'h0000_013E) | 32'd1;
            engDout   = $urandom;
            runLen    = $urandom_range(2, 10);
            launchDly = $urandom_range(0, 3);
            apbWrite(5'h04, $urandom, "rSaddr");
            apbRead(5'h04, "rSaddrRd");
            apbWrite(5'h08, $urandom, "rTx");
            apbWrite(5'h00, ctrl, "rStart");
            waitDone("rXfer");
            apbRead(5'h00, "rCtrlRd");
            if ($urandom_range(0, 1) == 1) begin
                apbWrite(5'h10, 32'h6, "rW1C");
                checkOutput("rIrqClr", 32'(irq), 32'd0);
            end
        end
    endtask

    // Behavioural engine: leaves IDLE some cycles after a request, then returns a word.
    initial begin
        istateDrv = 4'd0;
        doutDrv   = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (engineOn && rst && i2c_enable) begin
                engineBusy = 1'b1;
                seenDin    = i2c_din;
                seenAddr   = i2c_addr;
                seenMode   = {i2c_bytcount, i2c_rep, i2c_da, i2c_rw};
                repeat (launchDly) @(posedge clk);
                #1;
                istateDrv = 4'($urandom_range(1, 15));
                repeat (runLen) @(posedge clk);
                #1;
                doutDrv    = engDout;
                istateDrv  = 4'd0;
                engineBusy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (pready !== 1'b1) preadyBad++;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog simulation did not finish actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int enCount;
        rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 5'd0; pwdata = 32'd0;
        mCtrl = 0; mSaddr = 0; mTx = 0; mRx = 0; mDone = 0; mErr = 0; mBusy = 0;
        repeat (3) @(negedge clk);
        checkOutput("rstEnable", 32'(i2c_enable), 32'd0);
        checkOutput("rstIrq", 32'(irq), 32'd0);
        checkOutput("rstPrdata", prdata, 32'd0);
        checkOutput("rstSlverr", 32'(pslverr), 32'd0);
        rst = 1'b1;

        for (int a = 0; a < 8; a++) apbRead(5'(a * 4), "rstRead");

        engDout = $urandom; runLen = 6; launchDly = 2;
        apbWrite(5'h04, 32'h50, "t2Saddr");
        apbWrite(5'h08, 32'hA5A5_1234, "t2Tx");
        apbWrite(5'h00, 32'h131, "t2Start");
        waitDone("t2");
        checkOutput("t2IrqSet", 32'(irq), 32'd1);
        apbWrite(5'h10, 32'h2, "t2W1C");
        checkOutput("t2IrqClr", 32'(irq), 32'd0);

        engDout = 32'h0000_00C3; runLen = 4; launchDly = 0;
        apbWrite(5'h00, 32'h007, "t3Start");
        waitDone("t3");

        apbRead(5'h14, "unmapped14");
        apbRead(5'h1C, "unmapped1C");
        apbWrite(5'h0C, 32'hDEAD_BEEF, "rxWrite");
        apbRead(5'h0C, "rxAfterWrite");

        engDout = $urandom; runLen = 30; launchDly = 1;
        apbWrite(5'h08, $urandom, "t4Tx");
        apbWrite(5'h00, 32'h011, "t4Start");
        waitEngineActive("t4");
        repeat (2) @(negedge clk);
        apbWrite(5'h08, 32'hFFFF_FFFF, "t4BusyTx");
        checkOutput("t4Din", i2c_din, mTx);
        apbWrite(5'h04, 32'h7F, "t4BusySaddr");
        apbWrite(5'h00, 32'h001, "t4BusyStart");
        apbRead(5'h10, "t4StatusBusy");
        waitDone("t4");

        engineOn = 1'b0;
        apbWrite(5'h00, 32'h101, "t5Start");
        enCount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i2c_enable) enCount++;
        end
        mBusy = 1'b0;
        mErr  = 1'b1;
        checkOutput("t5EnableCycles", 32'(enCount), 32'd16);
        checkOutput("t5Enable", 32'(i2c_enable), 32'd0);
        checkOutput("t5Irq", 32'(irq), 32'd0);
        apbRead(5'h10, "t5Status");
        engineOn = 1'b1;

        applyStimulus(4);

        engDout = $urandom; runLen = 30; launchDly = 1;
        apbWrite(5'h00, 32'h101, "t6Start");
        waitEngineActive("t6");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        istateDrv = 4'd0;
        #1;
        mCtrl = 0; mSaddr = 0; mTx = 0; mRx = 0; mDone = 0; mErr = 0; mBusy = 0;
        checkOutput("t6Enable", 32'(i2c_enable), 32'd0);
        checkOutput("t6Irq", 32'(irq), 32'd0);
        apbRead(5'h10, "t6Status");
        apbRead(5'h0C, "t6Rxdata");
        apbRead(5'h00, "t6Ctrl");
        @(negedge clk);
        rst = 1'b1;
        repeat (35) @(negedge clk);
        applyStimulus(2);

        checkOutput("preadyLow", 32'(preadyBad), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
